// File: rtl/ubutterfly_pkg.sv
// Shared types, latencies and the write-back saturator for the radix-2 butterfly sequencer.
package ubutterfly_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam int unsigned RD_LAT = 1;
  localparam int unsigned BF_LAT = 4;
  localparam int unsigned WB_LAT = RD_LAT + BF_LAT;

  localparam int unsigned DW = 8;
  localparam int unsigned OW = 16;

  localparam logic signed [OW-1:0] SAT_MAX = 16'sd127;
  localparam logic signed [OW-1:0] SAT_MIN = -16'sd128;

  // Clamp a scaled butterfly output into the 8-bit sample range.
  function automatic logic signed [DW-1:0] sat8(input logic signed [OW-1:0] x);
    logic signed [DW-1:0] r;
    if (x > SAT_MAX)      r = 8'sd127;
    else if (x < SAT_MIN) r = -8'sd128;
    else                  r = DW'(x);
    return r;
  endfunction

endpackage

// File: rtl/fft_agu.sv
// Combinational address generator: (mode, stage, k) -> butterfly pair (i, j) and twiddle index.
module fft_agu #(
  parameter int unsigned LOG2N = 3
) (
  input  logic                       mode,
  input  logic [$clog2(LOG2N)-1:0]   stage,
  input  logic [LOG2N-2:0]           k,
  output logic [LOG2N-1:0]           i,
  output logic [LOG2N-1:0]           j,
  output logic [LOG2N-2:0]           tw
);

  localparam int unsigned AW = LOG2N;
  localparam int unsigned KW = LOG2N - 1;
  localparam int unsigned SW = $clog2(LOG2N);

  logic [SW-1:0] sh;
  logic [SW-1:0] twsh;
  logic [AW-1:0] kx;
  logic [AW-1:0] mask;
  logic [AW-1:0] lo;

  // DIT spans grow with stage, DIF spans shrink; both share the same bit-insert form.
  always_comb begin
    sh   = mode ? (SW'(LOG2N - 1) - stage) : stage;
    twsh = mode ? stage : (SW'(LOG2N - 1) - stage);
    kx   = AW'(k);
    mask = (AW'(1) << sh) - AW'(1);
    lo   = kx & mask;
    i    = (((kx >> sh) << sh) << 1) | lo;
    j    = i | (AW'(1) << sh);
    tw   = KW'(lo << twsh);
  end

endmodule

// File: rtl/ubutterfly_seq.sv
// In-place radix-2 FFT/IFFT sequencer: issues butterfly reads per stage and writes results back.
module ubutterfly_seq
  import ubutterfly_pkg::*;
#(
  parameter int unsigned LOG2N = 3,
  parameter int unsigned SCALE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    mode,
  output logic                    busy,
  output logic                    done,
  output logic                    rd_en,
  output logic [LOG2N-1:0]        rd_addr_a,
  output logic [LOG2N-1:0]        rd_addr_b,
  output logic [LOG2N-2:0]        tw_addr,
  input  logic signed [7:0]       rd_data_a,
  input  logic signed [7:0]       rd_data_b,
  input  logic signed [7:0]       tw_data,
  output logic signed [7:0]       bf_a,
  output logic signed [7:0]       bf_b,
  output logic signed [7:0]       bf_w,
  output logic                    bf_s,
  input  logic signed [15:0]      bf_outa,
  input  logic signed [15:0]      bf_outb,
  output logic                    wr_en,
  output logic [LOG2N-1:0]        wr_addr_a,
  output logic [LOG2N-1:0]        wr_addr_b,
  output logic signed [7:0]       wr_data_a,
  output logic signed [7:0]       wr_data_b
);

  localparam int unsigned AW  = LOG2N;
  localparam int unsigned KW  = LOG2N - 1;
  localparam int unsigned SW  = $clog2(LOG2N);
  localparam int unsigned DCW = $clog2(WB_LAT);
  localparam logic [KW-1:0]  K_LAST     = '1;
  localparam logic [SW-1:0]  STAGE_LAST = SW'(LOG2N - 1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(WB_LAT - 1);

  state_t         state, state_n;
  logic [SW-1:0]  stage, stage_n;
  logic [KW-1:0]  k, k_n;
  logic [DCW-1:0] drain, drain_n;
  logic           mode_q, mode_n;
  logic           issue_n;
  logic [AW-1:0]  agu_i, agu_j;
  logic [KW-1:0]  agu_tw;

  logic          dl_v [WB_LAT];
  logic [AW-1:0] dl_i [WB_LAT];
  logic [AW-1:0] dl_j [WB_LAT];

  logic signed [OW-1:0] sh_a, sh_b;

  // Next-state and counter sequencing.
  always_comb begin
    state_n = state;
    stage_n = stage;
    k_n     = k;
    drain_n = drain;
    mode_n  = mode_q;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = ISSUE;
          stage_n = '0;
          k_n     = '0;
          mode_n  = mode;
        end
      end
      ISSUE: begin
        if (k == K_LAST) begin
          state_n = DRAIN;
          drain_n = '0;
        end else begin
          k_n = k + KW'(1);
        end
      end
      DRAIN: begin
        if (drain == DRAIN_LAST) begin
          if (stage == STAGE_LAST) begin
            state_n = DONE;
          end else begin
            state_n = ISSUE;
            stage_n = stage + SW'(1);
            k_n     = '0;
          end
        end else begin
          drain_n = drain + DCW'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    issue_n = (state_n == ISSUE);
  end

  // Addresses are generated from next-cycle counters so the read strobe and addresses are registered.
  fft_agu #(.LOG2N(LOG2N)) u_agu (
    .mode  (mode_n),
    .stage (stage_n),
    .k     (k_n),
    .i     (agu_i),
    .j     (agu_j),
    .tw    (agu_tw)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      stage     <= '0;
      k         <= '0;
      drain     <= '0;
      mode_q    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
    end else begin
      state     <= state_n;
      stage     <= stage_n;
      k         <= k_n;
      drain     <= drain_n;
      mode_q    <= mode_n;
      busy      <= (state_n != IDLE);
      done      <= (state_n == DONE);
      rd_en     <= issue_n;
      rd_addr_a <= issue_n ? agu_i  : '0;
      rd_addr_b <= issue_n ? agu_j  : '0;
      tw_addr   <= issue_n ? agu_tw : '0;
    end
  end

  // Write-address delay line matching read plus butterfly latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 0; n < WB_LAT; n++) begin
        dl_v[n] <= 1'b0;
        dl_i[n] <= '0;
        dl_j[n] <= '0;
      end
    end else begin
      dl_v[0] <= rd_en;
      dl_i[0] <= rd_addr_a;
      dl_j[0] <= rd_addr_b;
      for (int n = 1; n < WB_LAT; n++) begin
        dl_v[n] <= dl_v[n-1];
        dl_i[n] <= dl_i[n-1];
        dl_j[n] <= dl_j[n-1];
      end
    end
  end

  assign bf_s      = mode_q;
  assign bf_a      = rd_data_a;
  assign bf_b      = rd_data_b;
  assign bf_w      = tw_data;

  assign wr_en     = dl_v[WB_LAT-1];
  assign wr_addr_a = dl_i[WB_LAT-1];
  assign wr_addr_b = dl_j[WB_LAT-1];

  // Scale and clamp; data is forced to zero whenever no write is in progress.
  assign sh_a      = bf_outa >>> SCALE;
  assign sh_b      = bf_outb >>> SCALE;
  assign wr_data_a = wr_en ? sat8(sh_a) : '0;
  assign wr_data_b = wr_en ? sat8(sh_b) : '0;

endmodule

// File: tb/tb_ubutterfly_seq.sv
// Scoreboard bench for ubutterfly_seq (N=8, SCALE=1): expected reads/writes queued at start, checked by a monitor.
module tb_ubutterfly_seq;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic mode;
  logic busy, done, rd_en, bf_s, wr_en;
  logic [2:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [1:0] tw_addr;
  logic signed [7:0] rd_data_a, rd_data_b, tw_data;
  logic signed [7:0] bf_a, bf_b, bf_w, wr_data_a, wr_data_b;
  logic signed [15:0] bf_outa, bf_outb;

  ubutterfly_seq #(.LOG2N(3), .SCALE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .busy(busy), .done(done), .rd_en(rd_en),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .tw_data(tw_data),
    .bf_a(bf_a), .bf_b(bf_b), .bf_w(bf_w), .bf_s(bf_s),
    .bf_outa(bf_outa), .bf_outb(bf_outb),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .wr_data_a(wr_data_a), .wr_data_b(wr_data_b)
  );

  always #5 clk = ~clk;

  typedef struct { int i; int j; int tw; int cyc; } rd_t;
  typedef struct { int i; int j; int da; int db; int cyc; } wr_t;

  rd_t rd_q[$];
  wr_t wr_q[$];

  int dit_i  [12] = '{0,2,4,6, 0,1,4,5, 0,1,2,3};
  int dit_j  [12] = '{1,3,5,7, 2,3,6,7, 4,5,6,7};
  int dit_tw [12] = '{0,0,0,0, 0,2,0,2, 0,1,2,3};
  int dif_i  [12] = '{0,1,2,3, 0,1,4,5, 0,2,4,6};
  int dif_j  [12] = '{4,5,6,7, 2,3,6,7, 1,3,5,7};
  int dif_tw [12] = '{0,1,2,3, 0,2,0,2, 0,0,0,0};

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int busy_cyc = 0;
  int done_cnt = 0;
  int exp_done = -1;
  bit exp_mode = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d: got output with nothing expected", name, cyc);
  endtask

  // Queue the hand-computed read/write schedule for one transform started in cycle s.
  task automatic push_tf(input bit m, input int da, input int db, input int s);
    int n;
    rd_t r;
    wr_t w;
    for (int st = 0; st < 3; st++) begin
      for (int kk = 0; kk < 4; kk++) begin
        n     = st * 4 + kk;
        r.i   = m ? dif_i[n]  : dit_i[n];
        r.j   = m ? dif_j[n]  : dit_j[n];
        r.tw  = m ? dif_tw[n] : dit_tw[n];
        r.cyc = s + 1 + st * 9 + kk;
        rd_q.push_back(r);
        w.i   = r.i;
        w.j   = r.j;
        w.da  = da;
        w.db  = db;
        w.cyc = r.cyc + 5;
        wr_q.push_back(w);
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a read, a write or done.
  always @(negedge clk) begin
    rd_t r;
    wr_t w;
    if (rst) begin
      if (busy) busy_cyc++;
      if (rd_en) begin
        if (rd_q.size() == 0) unexpected("rd_en");
        else begin
          r = rd_q.pop_front();
          chk("rd_addr_a", int'(rd_addr_a), r.i);
          chk("rd_addr_b", int'(rd_addr_b), r.j);
          chk("tw_addr",   int'(tw_addr),   r.tw);
          chk("rd_cycle",  cyc,             r.cyc);
          chk("bf_s",      int'(bf_s),      int'(exp_mode));
        end
      end
      if (wr_en) begin
        if (wr_q.size() == 0) unexpected("wr_en");
        else begin
          w = wr_q.pop_front();
          chk("wr_addr_a", int'(wr_addr_a), w.i);
          chk("wr_addr_b", int'(wr_addr_b), w.j);
          chk("wr_data_a", int'(wr_data_a), w.da);
          chk("wr_data_b", int'(wr_data_b), w.db);
          chk("wr_cycle",  cyc,             w.cyc);
        end
      end
      if (done) begin
        chk("done_cycle", cyc, exp_done);
        chk("busy_len",   busy_cyc, 28);
        done_cnt++;
        busy_cyc = 0;
      end
    end
  end

  // Launch one transform; optionally pulse start again while busy; mode toggles mid-transform.
  task automatic run_tf(input bit m, input int oa, input int ob, input int ea, input int eb, input bit poke);
    int s;
    int d0;
    @(posedge clk); #1;
    bf_outa  = 16'(oa);
    bf_outb  = 16'(ob);
    mode     = m;
    start    = 1'b1;
    s        = cyc;
    d0       = done_cnt;
    exp_mode = m;
    exp_done = s + 28;
    busy_cyc = 0;
    push_tf(m, ea, eb, s);
    @(posedge clk); #1;
    start = 1'b0;
    mode  = ~m;
    if (poke) begin
      while (cyc < s + 10) begin @(posedge clk); #1; end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    while (cyc < s + 32) begin @(posedge clk); #1; end
    chk("done_count", done_cnt - d0, 1);
    chk("rd_q_drained", rd_q.size(), 0);
    chk("wr_q_drained", wr_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int cnt;
    rst = 1'b0; start = 1'b0; mode = 1'b0;
    rd_data_a = -8'sd5; rd_data_b = 8'sd17; tw_data = -8'sd128;
    bf_outa = '0; bf_outb = '0;
    #3;
    chk("rst_busy",  int'(busy),  0);
    chk("rst_done",  int'(done),  0);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_bf_s",  int'(bf_s),  0);
    chk("bf_a_pass", int'(bf_a), -5);
    chk("bf_b_pass", int'(bf_b), 17);
    chk("bf_w_pass", int'(bf_w), -128);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1;

    run_tf(1'b0,  600, -300,  127, -128, 1'b1);
    run_tf(1'b1,   -7,    5,   -4,    2, 1'b0);

    // Reset during stage-1 issue of a DIF transform.
    @(posedge clk); #1;
    bf_outa = 16'sd100; bf_outb = -16'sd100;
    mode = 1'b1; start = 1'b1; s = cyc;
    exp_mode = 1'b1; exp_done = -1; busy_cyc = 0;
    push_tf(1'b1, 50, -50, s);
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < s + 11) begin @(posedge clk); #1; end
    #2;
    rst = 1'b0;
    #1;
    chk("arst_busy",      int'(busy),      0);
    chk("arst_done",      int'(done),      0);
    chk("arst_rd_en",     int'(rd_en),     0);
    chk("arst_wr_en",     int'(wr_en),     0);
    chk("arst_bf_s",      int'(bf_s),      0);
    chk("arst_rd_addr_a", int'(rd_addr_a), 0);
    chk("arst_rd_addr_b", int'(rd_addr_b), 0);
    chk("arst_tw_addr",   int'(tw_addr),   0);
    chk("arst_wr_addr_a", int'(wr_addr_a), 0);
    chk("arst_wr_addr_b", int'(wr_addr_b), 0);
    chk("arst_wr_data_a", int'(wr_data_a), 0);
    chk("arst_wr_data_b", int'(wr_data_b), 0);
    rd_q.delete();
    wr_q.delete();
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b1;
    cnt = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (wr_en || rd_en || busy) cnt++;
    end
    chk("post_rst_quiet", cnt, 0);

    run_tf(1'b0,  254, -256,  127, -128, 1'b0);
    run_tf(1'b1,  256, -258,  127, -128, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
